// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and helpers for the sequential divider
//
// Purpose: state encoding for the divider control FSM and a ceiling-log2
//          helper used to size the step counter.
// Ports:   none (package).

package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit into the partial remainder and
//          attempts to subtract the divisor, producing one quotient bit.
// Ports:
//   rem       in  DATA_WIDTH  current partial remainder
//   next_bit  in  1           next dividend bit (quotient register MSB)
//   divisor   in  DATA_WIDTH  divisor
//   rem_next  out DATA_WIDTH  updated partial remainder
//   q_bit     out 1           quotient bit for this step

module divider_step #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  next_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);

  // Trial subtraction at DATA_WIDTH+1 bits: the shifted remainder can
  // exceed DATA_WIDTH bits for one step before the subtraction.
  logic [DATA_WIDTH:0] trial;

  assign trial = {rem, next_bit} - {1'b0, divisor};

  // For a non-zero divisor the remainder stays below the divisor, so the
  // top trial bit is exactly the borrow. A zero divisor always "fits",
  // which yields all-ones quotient and the dividend as remainder.
  assign q_bit = ~trial[DATA_WIDTH] | ~(|divisor);

  // A kept trial is below the divisor, so its top bit is zero; with a
  // zero divisor only the low bits ever shift onward. Either way the
  // stored remainder loses nothing by dropping the top bit.
  assign rem_next = q_bit ? trial[DATA_WIDTH-1:0] : {rem[DATA_WIDTH-2:0], next_bit};

endmodule

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - iterative unsigned restoring divider
//
// Purpose: accepts a dividend/divisor pair on i_start and produces the
//          quotient and remainder after DATA_WIDTH compute cycles.
// Ports:
//   i_clk          in  1           clock, rising edge
//   i_rst          in  1           asynchronous active-high reset
//   i_start        in  1           divide request, sampled only when idle
//   i_dividend     in  DATA_WIDTH  unsigned dividend
//   i_divisor      in  DATA_WIDTH  unsigned divisor
//   o_busy         out 1           high while computing and in the done cycle
//   o_done         out 1           one-cycle pulse, results valid
//   o_quotient     out DATA_WIDTH  quotient, held until the next o_done
//   o_remainder    out DATA_WIDTH  remainder, held until the next o_done
//   o_div_by_zero  out 1           divisor was zero, held until the next o_done

module sequential_divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_div_by_zero
);

  localparam int CNT_W = clog2(DATA_WIDTH + 1);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] divisor_r;

  logic [DATA_WIDTH-1:0] rem_next;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] q_next;

  divider_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem      (rem),
    .next_bit (q[DATA_WIDTH-1]),
    .divisor  (divisor_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // The quotient register doubles as the dividend shifter: dividend bits
  // leave at the MSB while quotient bits enter at the LSB.
  assign q_next = {q[DATA_WIDTH-2:0], q_bit};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      q             <= '0;
      divisor_r     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            divisor_r <= i_divisor;
            rem       <= '0;
            q         <= i_dividend;
            cnt       <= CNT_W'(DATA_WIDTH);
            o_busy    <= 1'b1;
            state     <= CALC;
          end
        end

        CALC: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          // Last step: results come straight from the step logic so they
          // are valid on the same edge the counter reaches zero.
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            o_done        <= 1'b1;
            o_quotient    <= q_next;
            o_remainder   <= rem_next;
            o_div_by_zero <= (divisor_r == '0);
          end
        end

        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - self-checking bench for sequential_divider

module tb_sequential_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;

  sequential_divider #(
    .DATA_WIDTH(W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_div_by_zero"}, 32'(dbz), 32'(e.dbz));
    end
  endtask

  // Called on a negedge; the following rising edge accepts the request.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered on the first negedge after acceptance. lat is the number of
  // edges after acceptance at which o_done was seen; optional start pulse
  // (9/3) is driven pulse_at cycles after acceptance to test it is ignored.
  task automatic run(input string tag, input int pulse_at, output int lat, output int busy_cyc);
    lat      = -1;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == pulse_at) begin
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd3;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        if (lat < 0) lat = i;
        pop_check(tag);
      end
      if (busy !== 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    int dc;
    int first;
    int second;
    int sweep_fail_start;

    // Reset state, applied asynchronously from time zero
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 13 / 4: latency and busy length
    start_div(4'd13, 4'd4);
    run("div13_4", -1, lat, bc);
    check("div13_4_latency", 32'(lat), 32'(W));
    check("div13_4_busy_cycles", 32'(bc), 32'(W + 1));

    // 7 / 0: divide by zero, same latency
    start_div(4'd7, 4'd0);
    run("div7_0", -1, lat, bc);
    check("div7_0_latency", 32'(lat), 32'(W));
    check("div7_0_busy_cycles", 32'(bc), 32'(W + 1));

    // 13 / 4 with a start pulse during CALC: ignored
    dc = done_count;
    start_div(4'd13, 4'd4);
    run("ignore_start", 2, lat, bc);
    repeat (W + 3) @(negedge clk);
    check("ignore_start_done_count", 32'(done_count - dc), 32'd1);
    check("ignore_start_idle", 32'(busy), 32'd0);

    // 15 / 2 aborted by reset mid-CALC
    start_div(4'd15, 4'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    sb.delete();
    dc = done_count;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    start_div(4'd15, 4'd2);
    run("after_abort", -1, lat, bc);
    check("after_abort_latency", 32'(lat), 32'(W));

    // Back-to-back with start held high: 12/5 then 0/3
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    push_exp(4'd12, 4'd5);
    @(negedge clk);
    dividend = 4'd0;
    divisor  = 4'd3;
    push_exp(4'd0, 4'd3);
    first  = -1;
    second = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        pop_check("b2b");
        if (first < 0) begin
          first = i;
        end else begin
          second = i;
          start  = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_first_latency", 32'(first), 32'(W));
    check("b2b_gap", 32'(second - first), 32'(W + 2));
    repeat (3) @(negedge clk);
    check("b2b_pending", 32'(sb.size()), 32'd0);
    sb.delete();

    // Exhaustive sweep
    sweep_fail_start = n_fail;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_div(4'(a), 4'(b));
        run($sformatf("sweep_%0d_%0d", a, b), -1, lat, bc);
        check($sformatf("sweep_%0d_%0d_latency", a, b), 32'(lat), 32'(W));
        if (b != 0) begin
          check($sformatf("sweep_%0d_%0d_identity", a, b),
                32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
          check($sformatf("sweep_%0d_%0d_rem_lt_div", a, b),
                32'(remainder < 4'(b)), 32'd1);
        end
      end
    end
    if (n_fail == sweep_fail_start) $display("exhaustive sweep PASSED");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
